// File: rtl/datamem_responder_if.sv
//==============================================================================
// Module      : datamem_responder_if
// Description : Request/response channel between the CPU MEM stage (master)
//               and the data-memory responder (slave).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface datamem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [63:0] req_addr;
    logic [1:0]  req_size;
    logic [63:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_write, req_addr, req_size, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_size, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

`default_nettype wire

// File: rtl/datamem_responder.sv
//==============================================================================
// Module      : datamem_responder
// Description : Byte-addressed little-endian data memory with programmable
//               wait states; one outstanding load/store at a time.
//               Optional macro DATAMEM_ALIGN_CHECK_EN faults misaligned access.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module datamem_responder #(
    parameter int DEPTH_BYTES = 1024,
    parameter int LATENCY     = 2
) (
    input  wire logic           clk,
    input  wire logic           reset,
    datamem_responder_if.slave  bus
);

    localparam int         c_addr_w  = $clog2(DEPTH_BYTES);
    localparam logic [3:0] c_lat_ld  = 4'(LATENCY);
    localparam logic [64:0] c_depth  = 65'(DEPTH_BYTES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [3:0]          r_cnt;
    logic [3:0]          w_cnt_nxt;
    logic [63:0]         r_rdata;
    logic                r_err;
    logic [7:0]          r_mem [DEPTH_BYTES];

    logic                w_accept;
    logic                w_fault;
    logic                w_misalign;
    logic [3:0]          w_nbytes;
    logic [64:0]         w_last;
    logic [c_addr_w-1:0] w_base;
    logic [63:0]         w_rbytes;

    assign w_nbytes = 4'd1 << bus.req_size;
    assign w_base   = bus.req_addr[c_addr_w-1:0];
    // 65-bit sum so addresses near 2^64 cannot wrap back into range
    assign w_last   = {1'b0, bus.req_addr} + 65'(w_nbytes) - 65'd1;

`ifdef DATAMEM_ALIGN_CHECK_EN
    assign w_misalign = (bus.req_addr[2:0] & (w_nbytes[2:0] - 3'd1)) != 3'd0;
`else
    assign w_misalign = 1'b0;
`endif

    assign w_fault  = (w_last >= c_depth) | w_misalign;
    assign w_accept = bus.req_valid & bus.req_ready;

    always_comb begin
        w_rbytes = '0;
        for (int i = 0; i < 8; i++) begin
            if (4'(i) < w_nbytes) begin
                w_rbytes[8*i +: 8] = r_mem[w_base + c_addr_w'(i)];
            end
        end
    end

    // Storage is deliberately left out of reset so committed stores survive it
    always_ff @(posedge clk) begin
        if (w_accept && bus.req_write && !w_fault) begin
            for (int i = 0; i < 8; i++) begin
                if (4'(i) < w_nbytes) begin
                    r_mem[w_base + c_addr_w'(i)] <= bus.req_wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_rdata <= 64'd0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_accept) begin
                r_err   <= w_fault;
                r_rdata <= (bus.req_write || w_fault) ? 64'd0 : w_rbytes;
            end
        end
    end

    // Counter is loaded with LATENCY and WAIT is always visited, so the
    // response appears exactly LATENCY+1 edges after the accept edge.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = S_WAIT;
                    w_cnt_nxt   = c_lat_ld;
                end
            end
            S_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt = S_RESP;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            S_RESP: begin
                if (bus.resp_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = 4'd0;
            end
        endcase
    end

    // Gating with reset keeps req_ready low for as long as reset is held
    assign bus.req_ready  = (r_state == S_IDLE) & reset;
    assign bus.resp_valid = (r_state == S_RESP);
    assign bus.resp_rdata = r_rdata;
    assign bus.resp_err   = r_err;

endmodule

`default_nettype wire

// File: tb/tb_datamem_responder.sv
//==============================================================================
// Module      : tb_datamem_responder
// Description : Self-checking bench; drives a LATENCY=2 and a LATENCY=0
//               responder with identical requests against a byte-array model.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_datamem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_write;
    logic [63:0] req_addr;
    logic [1:0]  req_size;
    logic [63:0] req_wdata;
    logic        resp_ready;

    int checks   = 0;
    int failures = 0;

    logic [7:0] mdl [1024];

    always #5 clk = ~clk;

    datamem_responder_if bus2 ();
    datamem_responder_if bus0 ();

    assign bus2.req_valid  = req_valid;
    assign bus2.req_write  = req_write;
    assign bus2.req_addr   = req_addr;
    assign bus2.req_size   = req_size;
    assign bus2.req_wdata  = req_wdata;
    assign bus2.resp_ready = resp_ready;
    assign bus0.req_valid  = req_valid;
    assign bus0.req_write  = req_write;
    assign bus0.req_addr   = req_addr;
    assign bus0.req_size   = req_size;
    assign bus0.req_wdata  = req_wdata;
    assign bus0.resp_ready = resp_ready;

    datamem_responder #(.DEPTH_BYTES(1024), .LATENCY(2)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2)
    );

    datamem_responder #(.DEPTH_BYTES(1024), .LATENCY(0)) u_dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0)
    );

    function automatic logic model_fault(input logic [63:0] a, input logic [1:0] s);
        logic [64:0] last;
        logic        f;
        last = {1'b0, a} + 65'(64'd1 << s) - 65'd1;
        f    = (last >= 65'd1024);
`ifdef DATAMEM_ALIGN_CHECK_EN
        if ((a & ((64'd1 << s) - 64'd1)) != 64'd0) f = 1'b1;
`endif
        return f;
    endfunction

    function automatic logic [63:0] model_load(input logic [63:0] a, input logic [1:0] s);
        logic [63:0] r;
        r = 64'd0;
        if (!model_fault(a, s)) begin
            for (int i = 0; i < (1 << s); i++) r[8*i +: 8] = mdl[int'(a[9:0]) + i];
        end
        return r;
    endfunction

    task automatic model_store(input logic [63:0] a, input logic [1:0] s, input logic [63:0] d);
        if (!model_fault(a, s)) begin
            for (int i = 0; i < (1 << s); i++) mdl[int'(a[9:0]) + i] = d[8*i +: 8];
        end
    endtask

    // Issues one request to both DUTs; reports each one's first resp_valid edge
    task automatic do_req(input logic w, input logic [63:0] a, input logic [1:0] s,
                          input logic [63:0] d, input bit hold,
                          output logic [63:0] rd, output logic er, output int n2,
                          output logic [63:0] rd0, output logic er0, output int n0);
        int g;
        rd = '0; er = 1'b0; rd0 = '0; er0 = 1'b0; n2 = 0; n0 = 0;
        @(negedge clk);
        g = 0;
        while (!(bus2.req_ready && bus0.req_ready) && g < 50) begin
            @(negedge clk);
            g++;
        end
        checks++;
        if (g >= 50) begin
            failures++;
            $display("FAIL req_ready_timeout: ready2=%b ready0=%b required 1", bus2.req_ready, bus0.req_ready);
        end
        req_write = w; req_addr = a; req_size = s; req_wdata = d; req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_addr  = {$urandom, $urandom};
        req_wdata = {$urandom, $urandom};
        req_size  = 2'($urandom);
        req_write = 1'($urandom);
        for (int c = 1; c <= 40; c++) begin
            if (n2 != 0 && n0 != 0) break;
            @(posedge clk);
            #1;
            if (n2 == 0 && bus2.resp_valid) begin n2 = c; rd = bus2.resp_rdata; er = bus2.resp_err; end
            if (n0 == 0 && bus0.resp_valid) begin n0 = c; rd0 = bus0.resp_rdata; er0 = bus0.resp_err; end
        end
        checks++;
        if (n2 == 0 || n0 == 0) begin
            failures++;
            $display("FAIL resp_valid_timeout: n2=%0d n0=%0d required nonzero", n2, n0);
        end
        if (!hold) begin
            @(posedge clk);
            #1;
            checks++;
            if (bus2.resp_valid !== 1'b0 || bus2.req_ready !== 1'b1) begin
                failures++;
                $display("FAIL post_handshake: valid=%b ready=%b required 0/1", bus2.resp_valid, bus2.req_ready);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
        req_size = '0; req_wdata = '0; resp_ready = 1'b1;
        #12;
        checks++;
        if ({bus2.req_ready, bus2.resp_valid, bus2.resp_err, bus2.resp_rdata} !== 67'd0 ||
            {bus0.req_ready, bus0.resp_valid, bus0.resp_err, bus0.resp_rdata} !== 67'd0) begin
            failures++;
            $display("FAIL reset_outputs: dut2=%h dut0=%h required 0",
                     {bus2.req_ready, bus2.resp_valid, bus2.resp_err, bus2.resp_rdata},
                     {bus0.req_ready, bus0.resp_valid, bus0.resp_err, bus0.resp_rdata});
        end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (bus2.req_ready !== 1'b1 || bus2.resp_valid !== 1'b0 || bus0.req_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_release: ready=%b valid=%b ready0=%b required 1/0/1",
                     bus2.req_ready, bus2.resp_valid, bus0.req_ready);
        end
    endtask

    task automatic test_preload();
        logic [63:0] rd, rd0, d;
        logic er, er0;
        int n2, n0;
        for (int a = 0; a < 1024; a += 8) begin
            d = {$urandom, $urandom};
            do_req(1'b1, 64'(a), 2'd3, d, 1'b0, rd, er, n2, rd0, er0, n0);
            model_store(64'(a), 2'd3, d);
            checks++;
            if (er !== 1'b0 || rd !== 64'd0) begin
                failures++;
                $display("FAIL preload_store: addr=%0d err=%b rdata=%h required 0/0", a, er, rd);
            end
        end
    endtask

    task automatic test_directed();
        logic [63:0] rd, rd0;
        logic er, er0;
        int n2, n0;
        do_req(1'b1, 64'h10, 2'd3, 64'h1122334455667788, 1'b0, rd, er, n2, rd0, er0, n0);
        model_store(64'h10, 2'd3, 64'h1122334455667788);
        checks++;
        if (er !== 1'b0 || n2 != 3 || n0 != 1) begin
            failures++;
            $display("FAIL store_0x10: err=%b edges2=%0d edges0=%0d required 0/3/1", er, n2, n0);
        end
        do_req(1'b0, 64'h10, 2'd3, 64'd0, 1'b0, rd, er, n2, rd0, er0, n0);
        checks++;
        if (rd !== 64'h1122334455667788 || er !== 1'b0 || n2 != 3) begin
            failures++;
            $display("FAIL load_0x10: rdata=%h err=%b edges=%0d required 1122334455667788/0/3", rd, er, n2);
        end
        checks++;
        if (rd0 !== 64'h1122334455667788 || er0 !== 1'b0 || n0 != 1) begin
            failures++;
            $display("FAIL load_0x10_lat0: rdata=%h err=%b edges=%0d required 1122334455667788/0/1", rd0, er0, n0);
        end
        do_req(1'b0, 64'h11, 2'd0, 64'd0, 1'b0, rd, er, n2, rd0, er0, n0);
        checks++;
        if (rd !== 64'h77 || er !== 1'b0) begin
            failures++;
            $display("FAIL load_byte_0x11: rdata=%h err=%b required 77/0", rd, er);
        end
        do_req(1'b0, 64'h12, 2'd1, 64'd0, 1'b0, rd, er, n2, rd0, er0, n0);
        checks++;
        if (rd !== 64'h5566 || er !== 1'b0) begin
            failures++;
            $display("FAIL load_half_0x12: rdata=%h err=%b required 5566/0", rd, er);
        end
    endtask

    task automatic test_backpressure();
        logic [63:0] rd, rd0;
        logic er, er0;
        int n2, n0;
        resp_ready = 1'b0;
        do_req(1'b0, 64'h10, 2'd3, 64'd0, 1'b1, rd, er, n2, rd0, er0, n0);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            checks++;
            if (bus2.resp_valid !== 1'b1 || bus2.resp_rdata !== 64'h1122334455667788 || bus2.req_ready !== 1'b0) begin
                failures++;
                $display("FAIL backpressure_hold: valid=%b rdata=%h ready=%b required 1/1122334455667788/0",
                         bus2.resp_valid, bus2.resp_rdata, bus2.req_ready);
            end
        end
        @(negedge clk);
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (bus2.req_ready !== 1'b1 || bus2.resp_valid !== 1'b0 || bus0.req_ready !== 1'b1) begin
            failures++;
            $display("FAIL backpressure_release: ready=%b valid=%b ready0=%b required 1/0/1",
                     bus2.req_ready, bus2.resp_valid, bus0.req_ready);
        end
    endtask

    task automatic test_range();
        logic [63:0] rd, rd0, exp;
        logic er, er0;
        int n2, n0;
        do_req(1'b1, 64'd1020, 2'd3, {$urandom, $urandom}, 1'b0, rd, er, n2, rd0, er0, n0);
        checks++;
        if (er !== 1'b1 || rd !== 64'd0 || n2 != 3) begin
            failures++;
            $display("FAIL range_store_1020: err=%b rdata=%h edges=%0d required 1/0/3", er, rd, n2);
        end
        exp = {32'd0, mdl[1023], mdl[1022], mdl[1021], mdl[1020]};
        do_req(1'b0, 64'd1020, 2'd2, 64'd0, 1'b0, rd, er, n2, rd0, er0, n0);
        checks++;
        if (er !== 1'b0 || rd !== exp) begin
            failures++;
            $display("FAIL range_load_1020: err=%b rdata=%h required 0/%h", er, rd, exp);
        end
        do_req(1'b0, 64'd1023, 2'd0, 64'd0, 1'b0, rd, er, n2, rd0, er0, n0);
        checks++;
        if (er !== 1'b0 || rd !== {56'd0, mdl[1023]}) begin
            failures++;
            $display("FAIL range_load_1023: err=%b rdata=%h required 0/%h", er, rd, {56'd0, mdl[1023]});
        end
        do_req(1'b0, 64'hFFFF_FFFF_FFFF_FFF8, 2'd3, 64'd0, 1'b0, rd, er, n2, rd0, er0, n0);
        checks++;
        if (er !== 1'b1 || rd !== 64'd0 || n2 != 3) begin
            failures++;
            $display("FAIL range_wrap_addr: err=%b rdata=%h edges=%0d required 1/0/3", er, rd, n2);
        end
    endtask

    task automatic test_misaligned();
        logic [63:0] rd, rd0;
        logic er, er0;
        int n2, n0;
        do_req(1'b0, 64'h11, 2'd2, 64'd0, 1'b0, rd, er, n2, rd0, er0, n0);
        checks++;
`ifdef DATAMEM_ALIGN_CHECK_EN
        if (er !== 1'b1 || rd !== 64'd0) begin
            failures++;
            $display("FAIL misaligned_load: err=%b rdata=%h required 1/0", er, rd);
        end
`else
        if (er !== 1'b0 || rd !== 64'h44556677) begin
            failures++;
            $display("FAIL misaligned_load: err=%b rdata=%h required 0/44556677", er, rd);
        end
`endif
    endtask

    task automatic test_random();
        logic [63:0] rd, rd0, a, d, exp;
        logic [1:0]  s;
        logic        w, er, er0, expe;
        int n2, n0, r;
        for (int k = 0; k < 150; k++) begin
            r = int'($urandom_range(0, 9));
            if (r < 7)      a = 64'($urandom_range(0, 1023));
            else if (r < 9) a = 64'($urandom_range(1010, 1030));
            else            a = {$urandom, $urandom};
            s = 2'($urandom);
            w = 1'($urandom);
            d = {$urandom, $urandom};
            expe = model_fault(a, s);
            exp  = w ? 64'd0 : model_load(a, s);
            do_req(w, a, s, d, 1'b0, rd, er, n2, rd0, er0, n0);
            if (w) model_store(a, s, d);
            checks++;
            if (rd !== exp || er !== expe || n2 != 3 || n0 != 1 || rd0 !== exp || er0 !== expe) begin
                failures++;
                $display("FAIL random_op%0d w=%b a=%h s=%0d: rdata=%h err=%b edges=%0d/%0d rdata0=%h required %h/%b/3/1",
                         k, w, a, s, rd, er, n2, n0, rd0, exp, expe);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [63:0] rd, rd0, d;
        logic er, er0, seen;
        int n2, n0;
        // Reset while holding a load response in RESP
        resp_ready = 1'b0;
        do_req(1'b0, 64'h10, 2'd3, 64'd0, 1'b1, rd, er, n2, rd0, er0, n0);
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if ({bus2.req_ready, bus2.resp_valid, bus2.resp_err, bus2.resp_rdata} !== 67'd0) begin
            failures++;
            $display("FAIL reset_in_resp: outputs=%h required 0",
                     {bus2.req_ready, bus2.resp_valid, bus2.resp_err, bus2.resp_rdata});
        end
        @(negedge clk);
        reset = 1'b1;
        // Reset while a store waits in WAIT; the store must stay committed
        d = {$urandom, $urandom};
        resp_ready = 1'b1;
        @(negedge clk);
        req_write = 1'b1; req_addr = 64'h200; req_size = 2'd3; req_wdata = d; req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        model_store(64'h200, 2'd3, d);
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (bus2.resp_valid !== 1'b0 || bus2.req_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_in_wait: valid=%b ready=%b required 0/0", bus2.resp_valid, bus2.req_ready);
        end
        @(negedge clk);
        reset = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            if (bus2.resp_valid) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            failures++;
            $display("FAIL reset_discard: resp_valid seen=%b required 0", seen);
        end
        do_req(1'b0, 64'h200, 2'd3, 64'd0, 1'b0, rd, er, n2, rd0, er0, n0);
        checks++;
        if (rd !== d || er !== 1'b0) begin
            failures++;
            $display("FAIL store_survives_reset: rdata=%h err=%b required %h/0", rd, er, d);
        end
    endtask

    initial begin
        test_reset();
        test_preload();
        test_directed();
        test_backpressure();
        test_range();
        test_misaligned();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule

`default_nettype wire
